// File: rtl/spi_master_tx.sv
// SPI master transmitter: one cs-low frame per accepted byte, sclk idle low, mosi MSB first.
// Frame = sync period, WIDTH data periods, trailer period; the receiver samples on sclk falling edges.
module spi_master_tx #(
    parameter int CLK_DIV = 4,
    parameter int WIDTH   = 8,
    parameter int CS_GAP  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi
);

    localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PMAX = (WIDTH + 1 > CS_GAP - 1) ? WIDTH + 1 : CS_GAP - 1;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [CW-1:0] HALF_LAST     = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PER_LAST      = PW'(WIDTH + 1);
    localparam logic [PW-1:0] PER_DATA_LAST = PW'(WIDTH);
    localparam logic [PW-1:0] GAP_LAST      = PW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    half_q, half_d;
    logic [PW-1:0]    per_q, per_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             cs_q, cs_d;
    logic             mosi_q, mosi_d;
    logic             half_end;

    assign half_end = (half_q == HALF_LAST);

    always_comb begin
        state_d = state_q;
        half_d  = half_end ? '0 : half_q + CW'(1);
        per_d   = per_q;
        shift_d = shift_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;

        case (state_q)
            S_IDLE: begin
                half_d = '0;
                if (start && ready_q) begin
                    state_d = S_SETUP;
                    shift_d = din;
                    per_d   = '0;
                    ready_d = 1'b0;
                    cs_d    = 1'b0;
                end
            end
            S_SETUP: begin
                if (half_end) begin
                    state_d = S_HIGH;
                    per_d   = '0;
                    sclk_d  = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            S_HIGH: begin
                if (half_end) begin
                    state_d = S_LOW;
                    sclk_d  = 1'b0;
                end
            end
            S_LOW: begin
                if (half_end) begin
                    if (per_q != PER_LAST) begin
                        state_d = S_HIGH;
                        per_d   = per_q + PW'(1);
                        sclk_d  = 1'b1;
                        // periods 1..WIDTH carry data; the trailer period drives 0
                        if (per_q < PER_DATA_LAST) begin
                            mosi_d  = shift_q[WIDTH-1];
                            shift_d = shift_q << 1;
                        end else begin
                            mosi_d = 1'b0;
                        end
                    end else begin
                        state_d = S_GAP;
                        per_d   = '0;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (half_end) begin
                    if (per_q != GAP_LAST) begin
                        per_d = per_q + PW'(1);
                    end else if (start) begin
                        // a held start is taken on the edge ready would rise, so cs stays high exactly CS_GAP half-periods
                        state_d = S_SETUP;
                        shift_d = din;
                        per_d   = '0;
                        cs_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            half_q  <= '0;
            per_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            per_q   <= per_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: default instance (A) and a CLK_DIV=1 instance (B), with a receiver model
// that samples mosi on sclk falling edges and timing expectations computed from the frame formulas.
module tb_spi_master_tx;

    localparam int W = 8;
    localparam int G = 2;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b1;

    logic         start_a = 1'b0;
    logic [W-1:0] din_a = '0;
    logic         ready_a, done_a, sclk_a, cs_a, mosi_a;
    logic         start_b = 1'b0;
    logic [W-1:0] din_b = '0;
    logic         ready_b, done_b, sclk_b, cs_b, mosi_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int       falls_a[$], dones_a[$], rdys_a[$], csr_a[$], csf_a[$];
    bit       bits_a[$];
    logic [7:0] rxq_a[$];
    int       rx_cnt_a, toggles_a;
    logic [7:0] rx_sh_a;
    bit       overlap_a, mosi_hi_a;
    logic     p_sclk_a, p_mosi_a, p_cs_a, p_ready_a, p_done_a;

    int       falls_b[$], dones_b[$], rdys_b[$];
    logic [7:0] rxq_b[$];
    int       rx_cnt_b;
    logic [7:0] rx_sh_b;
    logic     p_sclk_b, p_mosi_b, p_cs_b, p_ready_b;

    spi_master_tx #(.CLK_DIV(4), .WIDTH(W), .CS_GAP(G)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .din(din_a),
        .ready(ready_a), .done(done_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a)
    );

    spi_master_tx #(.CLK_DIV(1), .WIDTH(W), .CS_GAP(G)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .din(din_b),
        .ready(ready_b), .done(done_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // expected timing of a frame accepted at edge acc, with h clk cycles per half-period
    function automatic int exp_fall(int acc, int h, int k);
        return acc + 2 * h + 2 * k * h;
    endfunction
    function automatic int exp_done(int acc, int h);
        return acc + (2 * W + 5) * h;
    endfunction
    function automatic int exp_ready(int acc, int h);
        return acc + (2 * W + 5 + G) * h;
    endfunction
    function automatic bit exp_bit(logic [W-1:0] d, int k);
        if (k == 0 || k == W + 1) return 1'b0;
        return d[W-k];
    endfunction

    task automatic clear_mon();
        falls_a.delete(); dones_a.delete(); rdys_a.delete(); csr_a.delete(); csf_a.delete();
        bits_a.delete(); rxq_a.delete();
        rx_cnt_a = 0; rx_sh_a = '0; toggles_a = 0; overlap_a = 0; mosi_hi_a = 0;
        p_sclk_a = sclk_a; p_mosi_a = mosi_a; p_cs_a = cs_a; p_ready_a = ready_a; p_done_a = done_a;
        falls_b.delete(); dones_b.delete(); rdys_b.delete(); rxq_b.delete();
        rx_cnt_b = 0; rx_sh_b = '0;
        p_sclk_b = sclk_b; p_mosi_b = mosi_b; p_cs_b = cs_b; p_ready_b = ready_b;
    endtask

    // advance one clock and record what both instances did on that edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (p_sclk_a && !sclk_a) begin
            falls_a.push_back(cyc);
            bits_a.push_back(p_mosi_a);
            if (!p_cs_a) begin
                if (rx_cnt_a >= 1 && rx_cnt_a <= W) rx_sh_a = {rx_sh_a[6:0], p_mosi_a};
                if (rx_cnt_a == W + 1) rxq_a.push_back(rx_sh_a);
                rx_cnt_a++;
            end
        end
        if (cs_a) rx_cnt_a = 0;
        if (done_a) dones_a.push_back(cyc);
        if (ready_a && !p_ready_a) rdys_a.push_back(cyc);
        if (cs_a && !p_cs_a) csr_a.push_back(cyc);
        if (!cs_a && p_cs_a) csf_a.push_back(cyc);
        if (done_a && ready_a) overlap_a = 1;
        if (mosi_a) mosi_hi_a = 1;
        if ({sclk_a, mosi_a, cs_a, ready_a, done_a} !== {p_sclk_a, p_mosi_a, p_cs_a, p_ready_a, p_done_a})
            toggles_a++;
        p_sclk_a = sclk_a; p_mosi_a = mosi_a; p_cs_a = cs_a; p_ready_a = ready_a; p_done_a = done_a;

        if (p_sclk_b && !sclk_b) begin
            falls_b.push_back(cyc);
            if (!p_cs_b) begin
                if (rx_cnt_b >= 1 && rx_cnt_b <= W) rx_sh_b = {rx_sh_b[6:0], p_mosi_b};
                if (rx_cnt_b == W + 1) rxq_b.push_back(rx_sh_b);
                rx_cnt_b++;
            end
        end
        if (cs_b) rx_cnt_b = 0;
        if (done_b) dones_b.push_back(cyc);
        if (ready_b && !p_ready_b) rdys_b.push_back(cyc);
        p_sclk_b = sclk_b; p_mosi_b = mosi_b; p_cs_b = cs_b; p_ready_b = ready_b;
    endtask

    task automatic test_reset();
        #5;
        rst_n = 1'b0;
        #1;
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b want 1", cs_a); end
        total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk_a); end
        total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
        clk_en = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        clear_mon();
        repeat (50) step();
        total++; if (toggles_a != 0) begin bad++; $display("FAIL idle_toggles: got %0d want 0", toggles_a); end
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b want 1", ready_a); end
    endtask

    task automatic test_single_frame();
        int acc;
        logic [W-1:0] d;
        d = 8'hA5;
        clear_mon();
        din_a = d; start_a = 1'b1;
        step();
        acc = cyc;
        start_a = 1'b0;
        repeat (100) step();
        total++; if (falls_a.size() != W + 2) begin bad++; $display("FAIL a5_falls: got %0d want %0d", falls_a.size(), W + 2); end
        for (int k = 0; k < falls_a.size() && k < W + 2; k++) begin
            total++; if (falls_a[k] != exp_fall(acc, 4, k)) begin bad++; $display("FAIL a5_fall_time k=%0d: got %0d want %0d", k, falls_a[k] - acc, exp_fall(acc, 4, k) - acc); end
            total++; if (bits_a[k] !== exp_bit(d, k)) begin bad++; $display("FAIL a5_bit k=%0d: got %b want %b", k, bits_a[k], exp_bit(d, k)); end
        end
        total++; if (dones_a.size() != 1) begin bad++; $display("FAIL a5_done_count: got %0d want 1", dones_a.size()); end
        else begin
            total++; if (dones_a[0] != exp_done(acc, 4)) begin bad++; $display("FAIL a5_done_time: got %0d want %0d", dones_a[0] - acc, exp_done(acc, 4) - acc); end
        end
        total++; if (rdys_a.size() != 1) begin bad++; $display("FAIL a5_ready_count: got %0d want 1", rdys_a.size()); end
        else begin
            total++; if (rdys_a[0] != exp_ready(acc, 4)) begin bad++; $display("FAIL a5_ready_time: got %0d want %0d", rdys_a[0] - acc, exp_ready(acc, 4) - acc); end
        end
        total++; if (csf_a.size() != 1 || csf_a[0] != acc) begin bad++; $display("FAIL a5_cs_fall: got %0d falls want 1 at accept", csf_a.size()); end
        total++; if (csr_a.size() != 1 || csr_a[0] != exp_done(acc, 4)) begin bad++; $display("FAIL a5_cs_rise: got %0d rises want 1 at done", csr_a.size()); end
        total++; if (rxq_a.size() != 1 || rxq_a[0] !== d) begin bad++; $display("FAIL a5_rx: got %0d bytes (first %h) want 1 byte %h", rxq_a.size(), (rxq_a.size() > 0) ? rxq_a[0] : 8'h00, d); end
        total++; if (overlap_a) begin bad++; $display("FAIL a5_done_ready_overlap: got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        int acc0;
        clear_mon();
        din_a = 8'h3C; start_a = 1'b1;
        step();
        acc0 = cyc;
        din_a = 8'hC3;
        while (cyc < acc0 + 92 + 100) begin
            step();
            if (cyc == acc0 + 92) start_a = 1'b0;
        end
        total++; if (rxq_a.size() != 2) begin bad++; $display("FAIL b2b_rx_count: got %0d want 2", rxq_a.size()); end
        else begin
            total++; if (rxq_a[0] !== 8'h3C) begin bad++; $display("FAIL b2b_rx0: got %h want 3c", rxq_a[0]); end
            total++; if (rxq_a[1] !== 8'hC3) begin bad++; $display("FAIL b2b_rx1: got %h want c3", rxq_a[1]); end
        end
        total++; if (dones_a.size() != 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", dones_a.size()); end
        else begin
            total++; if (dones_a[1] - dones_a[0] != 92) begin bad++; $display("FAIL b2b_done_spacing: got %0d want 92", dones_a[1] - dones_a[0]); end
        end
        total++; if (csr_a.size() < 1 || csf_a.size() < 2) begin bad++; $display("FAIL b2b_cs_edges: got %0d rises %0d falls want >=1 and >=2", csr_a.size(), csf_a.size()); end
        else begin
            total++; if (csf_a[1] - csr_a[0] != G * 4) begin bad++; $display("FAIL b2b_cs_gap: got %0d want %0d", csf_a[1] - csr_a[0], G * 4); end
        end
        total++; if (overlap_a) begin bad++; $display("FAIL b2b_done_ready_overlap: got 1 want 0"); end
    endtask

    task automatic test_ignore_start();
        int acc;
        clear_mon();
        din_a = 8'h00; start_a = 1'b1;
        step();
        acc = cyc;
        start_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cyc - acc == 9 || cyc - acc == 29 || cyc - acc == 59) begin
                start_a = 1'b1; din_a = 8'hFF;
            end else begin
                start_a = 1'b0;
            end
            step();
        end
        start_a = 1'b0;
        total++; if (mosi_hi_a) begin bad++; $display("FAIL ign_mosi: got 1 seen want 0 throughout"); end
        total++; if (dones_a.size() != 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", dones_a.size()); end
        total++; if (csf_a.size() != 1) begin bad++; $display("FAIL ign_frames: got %0d want 1", csf_a.size()); end
        total++; if (rxq_a.size() != 1 || rxq_a[0] !== 8'h00) begin bad++; $display("FAIL ign_rx: got %0d bytes want 1 byte 00", rxq_a.size()); end
    endtask

    task automatic test_mid_reset();
        int acc;
        clear_mon();
        din_a = 8'h81; start_a = 1'b1;
        step();
        acc = cyc;
        start_a = 1'b0;
        while (cyc < acc + 40) step();
        rst_n = 1'b0;
        #1;
        total++; if (cs_a !== 1'b1) begin bad++; $display("FAIL mrst_cs: got %b want 1", cs_a); end
        total++; if (sclk_a !== 1'b0) begin bad++; $display("FAIL mrst_sclk: got %b want 0", sclk_a); end
        total++; if (mosi_a !== 1'b0) begin bad++; $display("FAIL mrst_mosi: got %b want 0", mosi_a); end
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL mrst_ready: got %b want 1", ready_a); end
        total++; if (done_a !== 1'b0 || dones_a.size() != 0) begin bad++; $display("FAIL mrst_done: got %b (%0d pulses) want 0", done_a, dones_a.size()); end
        step();
        rst_n = 1'b1;
        clear_mon();
        din_a = 8'h5A; start_a = 1'b1;
        step();
        acc = cyc;
        start_a = 1'b0;
        repeat (100) step();
        total++; if (rxq_a.size() != 1 || rxq_a[0] !== 8'h5A) begin bad++; $display("FAIL mrst_rx: got %0d bytes (first %h) want 1 byte 5a", rxq_a.size(), (rxq_a.size() > 0) ? rxq_a[0] : 8'h00); end
        total++; if (dones_a.size() != 1 || dones_a[0] != exp_done(acc, 4)) begin bad++; $display("FAIL mrst_done_time: got %0d pulses want 1 at %0d", dones_a.size(), exp_done(acc, 4) - acc); end
    endtask

    task automatic test_div1();
        int acc;
        logic [W-1:0] vals[2];
        vals[0] = 8'hFF; vals[1] = 8'h00;
        for (int f = 0; f < 2; f++) begin
            clear_mon();
            din_b = vals[f]; start_b = 1'b1;
            step();
            acc = cyc;
            start_b = 1'b0;
            repeat (30) step();
            total++; if (falls_b.size() != W + 2) begin bad++; $display("FAIL div1_falls f=%0d: got %0d want %0d", f, falls_b.size(), W + 2); end
            for (int k = 0; k < falls_b.size() && k < W + 2; k++) begin
                total++; if (falls_b[k] != exp_fall(acc, 1, k)) begin bad++; $display("FAIL div1_fall_time f=%0d k=%0d: got %0d want %0d", f, k, falls_b[k] - acc, exp_fall(acc, 1, k) - acc); end
            end
            total++; if (dones_b.size() != 1 || dones_b[0] != exp_done(acc, 1)) begin bad++; $display("FAIL div1_done f=%0d: got %0d pulses want 1 at %0d", f, dones_b.size(), exp_done(acc, 1) - acc); end
            total++; if (rdys_b.size() != 1 || rdys_b[0] != exp_ready(acc, 1)) begin bad++; $display("FAIL div1_ready f=%0d: got %0d rises want 1 at %0d", f, rdys_b.size(), exp_ready(acc, 1) - acc); end
            total++; if (rxq_b.size() != 1 || rxq_b[0] !== vals[f]) begin bad++; $display("FAIL div1_rx f=%0d: got %0d bytes (first %h) want %h", f, rxq_b.size(), (rxq_b.size() > 0) ? rxq_b[0] : 8'h00, vals[f]); end
        end
    endtask

    task automatic test_random();
        int acc, n;
        logic [W-1:0] d;
        for (int f = 0; f < 4; f++) begin
            clear_mon();
            n = 0;
            while (!ready_a && n < 200) begin step(); n++; end
            total++; if (!ready_a) begin bad++; $display("FAIL rnd_wait_ready f=%0d: got 0 want 1", f); end
            repeat ($urandom_range(0, 5)) step();
            clear_mon();
            d = W'($urandom);
            din_a = d; start_a = 1'b1;
            step();
            acc = cyc;
            start_a = 1'b0;
            din_a = W'($urandom);
            repeat (95) step();
            total++; if (rxq_a.size() != 1 || rxq_a[0] !== d) begin bad++; $display("FAIL rnd_rx f=%0d: got %0d bytes (first %h) want %h", f, rxq_a.size(), (rxq_a.size() > 0) ? rxq_a[0] : 8'h00, d); end
            total++; if (dones_a.size() != 1 || dones_a[0] != exp_done(acc, 4)) begin bad++; $display("FAIL rnd_done f=%0d: got %0d pulses want 1 at %0d", f, dones_a.size(), exp_done(acc, 4) - acc); end
            total++; if (rdys_a.size() != 1 || rdys_a[0] != exp_ready(acc, 4)) begin bad++; $display("FAIL rnd_ready f=%0d: got %0d rises want 1 at %0d", f, rdys_a.size(), exp_ready(acc, 4) - acc); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_start();
        test_mid_reset();
        test_div1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master transmitter for the 8-bit SPI receiver already in the codebase, which samples mosi on the falling edge of sclk.
- Converts a parallel byte from a system-clock-domain producer into one chip-select frame: cs low, sclk idle low, mosi MSB first.
- Each frame carries one sync period, WIDTH data periods and one trailer period, so the receiver's cs-detect, sample and done phases all see a falling edge.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range >= 1.
- WIDTH, 8, data bits per frame; must match the receiver width.
- CS_GAP, 2, sclk half-periods that cs is held high after a frame before ready reasserts; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request to send; accepted only on a cycle where ready=1.
- din  input  WIDTH  byte to send; latched on the accept cycle.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse at the end of a frame.
- sclk  output  1  SPI clock; idles low.
- cs  output  1  chip select, active-low.
- mosi  output  1  serial data, MSB first.

Behaviour:
- Reset, asynchronous and immediate, including mid-frame: ready=1, done=0, sclk=0, cs=1, mosi=0. The shift register and all counters clear.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Accept: the rising clk edge where start & ready. On that edge din goes into the shift register and ready falls.
- start while ready=0 is ignored. din changes after accept have no effect.
- A half-period counter runs 0..CLK_DIV-1. A period counter runs 0..WIDTH+1.
- States and transitions:
  - IDLE: ready=1. On accept go to SETUP; cs=0 from the accept edge on.
  - SETUP: one half-period with sclk=0, cs=0, mosi=0. Then go to HIGH with period=0.
  - HIGH: sclk=1 for one half-period. On entry, mosi is set to the bit for this period:
    - period 0 (sync): 0
    - periods 1..WIDTH: din[WIDTH-1] down to din[0]
    - period WIDTH+1 (trailer): 0
    - At the end of the half-period go to LOW; sclk falls, and the receiver samples here.
  - LOW: sclk=0 for one half-period; mosi is held. At the end:
    - if period < WIDTH+1: increment period and go to HIGH;
    - else go to GAP, with cs=1, mosi=0 and done=1 for exactly one cycle.
  - GAP: cs=1, sclk=0 for CS_GAP half-periods. Then go to IDLE with ready=1.
- mosi is stable for a full half-period before and after every sclk falling edge.
- Timing, with accept at edge 0 and H=CLK_DIV:
  - cs low from edge 0.
  - First sclk rise at edge H.
  - Falling edges at edges 2H + 2kH, for k=0..WIDTH+1; that is WIDTH+2 falling edges per frame.
  - done=1 and cs=1 from edge (2WIDTH+5)H.
  - ready=1 from edge (2WIDTH+5+CS_GAP)H.
- Defaults (H=4, WIDTH=8, CS_GAP=2): done at cycle 84, ready at cycle 92, so the next accept is at the earliest on edge 92.
- Back-to-back: if start is held high, the next frame is accepted on the first cycle ready=1. cs therefore stays high for exactly CS_GAP*CLK_DIV cycles between frames.
- done and ready are never high in the same cycle.
- With CLK_DIV=1 every state lasts one clk cycle. Same sequence and count formulas apply.

Test Plan:
1. Assert rst_n=0 with no clk activity -> immediately ready=1, done=0, cs=1, sclk=0, mosi=0. Release, hold start=0 for 50 cycles -> no output toggles.
2. Defaults, din=0xA5, 1-cycle start, receiver model attached -> 10 sclk falling edges. mosi sampled at falling edges 2..9 = 1,0,1,0,0,1,0,1. done pulse at cycle 84. Receiver dout=0xA5 with its done=1. ready at cycle 92.
3. Hold start=1 with din=0x3C, then 0xC3 after the first accept -> two frames, receiver captures 0x3C then 0xC3. cs high for exactly 8 cycles between frames. Two done pulses, 92 cycles apart.
4. Pulse start and change din to 0xFF at cycles 10, 30 and 60 during a 0x00 frame -> ignored. mosi=0 throughout, one done pulse only.
5. Assert rst_n=0 at cycle 40 of a 0x81 frame -> same cycle cs=1, sclk=0, mosi=0, ready=1, no done. A new start of 0x5A then completes normally and the receiver captures 0x5A.
6. CLK_DIV=1, din=0xFF then 0x00 -> falling edges every 2 cycles, done at cycle 21. Receiver captures 0xFF and 0x00; ready at cycle 23.
